hazard_sequencer: RTL and testbench

- Sequential pipeline hazard controller; sits between the decode/execute pipeline registers and the PC/IF/ID/EX control inputs.
- Detects load-use hazards, taken branches and data-memory wait, and holds stall/flush windows for a programmable number of cycles.
- Resolves priority between simultaneous hazard sources and keeps saturating stall/flush statistics.

---
 rtl/hazard_sequencer.sv | 136 +++++++++++++
 tb/tb_hazard_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freeze, saturating stats.
// Zero-latency control outputs in the detecting cycle; MEM_busy overrides branch, which overrides load windows.
module hazard_sequencer #(
  parameter int LOAD_STALL_CYCLES   = 2,
  parameter int BRANCH_FLUSH_CYCLES = 2,
  parameter int CNT_W               = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MEMread,
  input  logic [4:0]       ID_EX_Rd,
  input  logic [4:0]       IF_ID_RsA,
  input  logic [4:0]       IF_ID_RsB,
  input  logic             branch,
  input  logic [31:0]      New_PC_add,
  input  logic             MEM_busy,
  input  logic             cnt_clr,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             PC_sel,
  output logic [31:0]      PC_add,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LSTALL   = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [3:0]       LS_REM  = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0]       BF_REM  = 4'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic [31:0] last_target;
  logic        load_use;
  logic        pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_flush_c, ex_mem_stall_c, pc_sel_c;

  assign load_use = ID_EX_MEMread && (ID_EX_Rd != 5'd0) &&
                    ((ID_EX_Rd == IF_ID_RsA) || (ID_EX_Rd == IF_ID_RsB));

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    pc_sel_c       = 1'b0;
    if (MEM_busy) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      state_d        = MEM_WAIT;
      rem_d          = 4'd0;
    end else if (branch) begin
      pc_sel_c      = 1'b1;
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      state_d       = (BRANCH_FLUSH_CYCLES > 1) ? FLUSH : RUN;
      rem_d         = (BRANCH_FLUSH_CYCLES > 1) ? BF_REM : 4'd0;
    end else begin
      case (state_q)
        LSTALL: begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
          state_d       = (rem_q <= 4'd1) ? RUN : LSTALL;
          rem_d         = (rem_q <= 4'd1) ? 4'd0 : rem_q - 4'd1;
        end
        FLUSH: begin
          if_id_flush_c = 1'b1;
          state_d       = (rem_q <= 4'd1) ? RUN : FLUSH;
          rem_d         = (rem_q <= 4'd1) ? 4'd0 : rem_q - 4'd1;
        end
        default: begin
          // RUN, and MEM_WAIT once memory is ready, share the same detection path.
          state_d = RUN;
          rem_d   = 4'd0;
          if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
            state_d       = (LOAD_STALL_CYCLES > 1) ? LSTALL : RUN;
            rem_d         = (LOAD_STALL_CYCLES > 1) ? LS_REM : 4'd0;
          end
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do.
  assign PC_stall     = rst_n & pc_stall_c;
  assign IF_ID_stall  = rst_n & if_id_stall_c;
  assign IF_ID_flush  = rst_n & if_id_flush_c;
  assign ID_EX_flush  = rst_n & id_ex_flush_c;
  assign EX_MEM_stall = rst_n & ex_mem_stall_c;
  assign PC_sel       = rst_n & pc_sel_c;
  assign PC_add       = PC_sel ? New_PC_add : last_target;
  assign state        = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      rem_q       <= 4'd0;
      last_target <= 32'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (PC_sel) last_target <= New_PC_add;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (cnt_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (PC_stall && stall_count != CNT_MAX) stall_count <= stall_count + 1'b1;
      if (PC_sel && flush_count != CNT_MAX) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: load-use, branch, memory wait, priority, reset and counter saturation.
module tb_hazard_sequencer;
  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ID_EX_MEMread;
  logic [4:0]       ID_EX_Rd, IF_ID_RsA, IF_ID_RsB;
  logic             branch;
  logic [31:0]      New_PC_add;
  logic             MEM_busy, cnt_clr;
  logic             PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, EX_MEM_stall, PC_sel;
  logic [31:0]      PC_add;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [5:0]       ctl;

  int n_chk = 0;
  int n_err = 0;

  // ctl = {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, EX_MEM_stall, PC_sel}
  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_LOAD   = 6'b110100;
  localparam logic [5:0] C_BRANCH = 6'b001101;
  localparam logic [5:0] C_FLUSH  = 6'b001000;
  localparam logic [5:0] C_MEM    = 6'b110010;

  hazard_sequencer #(.LOAD_STALL_CYCLES(2), .BRANCH_FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ID_EX_MEMread(ID_EX_MEMread), .ID_EX_Rd(ID_EX_Rd),
    .IF_ID_RsA(IF_ID_RsA), .IF_ID_RsB(IF_ID_RsB), .branch(branch), .New_PC_add(New_PC_add),
    .MEM_busy(MEM_busy), .cnt_clr(cnt_clr), .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
    .PC_sel(PC_sel), .PC_add(PC_add), .state(state), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;
  assign ctl = {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, EX_MEM_stall, PC_sel};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_EX_MEMread = 1'b0; ID_EX_Rd = 5'd7; IF_ID_RsA = 5'd1; IF_ID_RsB = 5'd1;
    branch = 1'b0; MEM_busy = 1'b0; cnt_clr = 1'b0;
  endtask

  // Apply current inputs, settle, then check control vector and state for this cycle.
  task automatic expect_cycle(input string tag, input logic [5:0] c, input logic [1:0] s);
    #1;
    chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    chk({tag, ".state"}, 32'(state), 32'(s));
  endtask

  initial begin
    idle();
    New_PC_add = 32'h0;
    rst_n = 1'b0;
    MEM_busy = 1'b1;
    #12;
    expect_cycle("reset_held", C_NONE, 2'd0);
    chk("reset_pcadd", PC_add, 32'h0);
    chk("reset_stallcnt", 32'(stall_count), 32'd0);
    MEM_busy = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    idle();
    expect_cycle("no_hazard", C_NONE, 2'd0);
    chk("no_hazard_pcadd", PC_add, 32'h0);
    tick();

    // load-use on A then on B: 2 stall cycles each
    for (int k = 0; k < 2; k++) begin
      ID_EX_MEMread = 1'b1;
      if (k == 0) IF_ID_RsA = 5'd7; else IF_ID_RsB = 5'd7;
      expect_cycle("lu_c0", C_LOAD, 2'd0);
      tick();
      idle();
      expect_cycle("lu_c1", C_LOAD, 2'd1);
      tick();
      expect_cycle("lu_done", C_NONE, 2'd0);
      chk("lu_stallcnt", 32'(stall_count), 32'(2 * (k + 1)));
    end

    ID_EX_MEMread = 1'b1; ID_EX_Rd = 5'd0; IF_ID_RsA = 5'd0;
    expect_cycle("r0_no_hazard", C_NONE, 2'd0);
    tick();
    idle();

    branch = 1'b1; New_PC_add = 32'hDEADBEEF;
    expect_cycle("br_c0", C_BRANCH, 2'd0);
    chk("br_c0_pcadd", PC_add, 32'hDEADBEEF);
    tick();
    branch = 1'b0; New_PC_add = 32'h12345678;
    expect_cycle("br_c1", C_FLUSH, 2'd2);
    chk("br_c1_pcadd", PC_add, 32'hDEADBEEF);
    tick();
    expect_cycle("br_done", C_NONE, 2'd0);
    chk("br_pcadd_hold", PC_add, 32'hDEADBEEF);
    chk("br_flushcnt", 32'(flush_count), 32'd1);

    ID_EX_MEMread = 1'b1; IF_ID_RsA = 5'd7; branch = 1'b1; New_PC_add = 32'h100;
    expect_cycle("br_lu_c0", C_BRANCH, 2'd0);
    chk("br_lu_pcadd", PC_add, 32'h100);
    tick();
    idle();
    expect_cycle("br_lu_c1", C_FLUSH, 2'd2);
    tick();
    expect_cycle("br_lu_done", C_NONE, 2'd0);
    chk("br_lu_stallcnt", 32'(stall_count), 32'd4);
    chk("br_lu_flushcnt", 32'(flush_count), 32'd2);

    // memory wait arriving in the second load-stall cycle abandons the window
    ID_EX_MEMread = 1'b1; IF_ID_RsA = 5'd7;
    expect_cycle("mw_lu", C_LOAD, 2'd0);
    tick();
    idle();
    MEM_busy = 1'b1;
    expect_cycle("mw_c0", C_MEM, 2'd1);
    tick();
    expect_cycle("mw_c1", C_MEM, 2'd3);
    tick();
    expect_cycle("mw_c2", C_MEM, 2'd3);
    tick();
    MEM_busy = 1'b0;
    expect_cycle("mw_release", C_NONE, 2'd3);
    tick();
    expect_cycle("mw_run", C_NONE, 2'd0);
    chk("mw_stallcnt", 32'(stall_count), 32'd8);

    branch = 1'b1; New_PC_add = 32'hCAFE0000;
    #1;
    tick();
    branch = 1'b0;
    expect_cycle("rst_mid_flush_pre", C_FLUSH, 2'd2);
    rst_n = 1'b0;
    expect_cycle("rst_mid_flush", C_NONE, 2'd0);
    chk("rst_mid_pcadd", PC_add, 32'h0);
    chk("rst_mid_flushcnt", 32'(flush_count), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    expect_cycle("rst_no_resume", C_NONE, 2'd0);

    MEM_busy = 1'b1;
    for (int i = 0; i < (1 << CNT_W) - 2; i++) tick();
    chk("sat_near", 32'(stall_count), 32'((1 << CNT_W) - 2));
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", 32'(stall_count), 32'((1 << CNT_W) - 1));
    cnt_clr = 1'b1;
    branch = 1'b0;
    tick();
    chk("clr_over_inc", 32'(stall_count), 32'd0);
    MEM_busy = 1'b0; branch = 1'b1; New_PC_add = 32'h4;
    tick();
    chk("clr_flushcnt", 32'(flush_count), 32'd0);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
